// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Arbitrates one shared single-port memory between an
//               instruction-fetch port and a data port. Data accesses win by
//               default, but a pending fetch is guaranteed a slot after at
//               most MAX_DATA_RUN consecutive data grants. An access that sees
//               no acknowledge for TIMEOUT granted cycles is aborted and
//               reported through o_error.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    // Instruction fetch port
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic [31:0] o_if_data,
    output logic        o_if_ready,

    // Data port
    input  logic        i_dm_req,
    input  logic        i_dm_rw,
    input  logic [15:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_ready,

    // Shared memory side
    output logic        o_mem_req,
    output logic        o_mem_rw,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,

    // Status
    output logic        o_stall,
    output logic        o_error
);

    // The run counter is at least 3 bits wide and must be able to hold
    // MAX_DATA_RUN itself, since it saturates at that value.
    localparam int c_RUN_W = (MAX_DATA_RUN > 7) ? $clog2(MAX_DATA_RUN + 1) : 3;
    // The timeout counter only ever needs to reach TIMEOUT-1.
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAX_DATA_RUN);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_END = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE = c_TMO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT_IF = 2'd1,
        S_GRANT_DM = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [c_RUN_W-1:0]   r_run;
    logic [c_TMO_W-1:0]   r_tmo;

    logic                 r_mem_req;
    logic                 r_mem_rw;
    logic [15:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [31:0]          r_if_data;
    logic [31:0]          r_dm_rdata;
    logic                 r_if_ready;
    logic                 r_dm_ready;
    logic                 r_error;

    logic                 w_run_sat;
    logic                 w_tmo_hit;
    logic                 w_pick_if;
    logic                 w_pick_dm;
    logic                 w_granted;

    // Arbitration decision, only acted upon while idle. The fetch overrides
    // a data request once the data port has used up its run allowance.
    assign w_run_sat = (r_run >= c_RUN_MAX);
    assign w_pick_dm = i_dm_req && !(i_if_req && w_run_sat);
    assign w_pick_if = i_if_req && !w_pick_dm;
    assign w_granted = (r_state == S_GRANT_IF) || (r_state == S_GRANT_DM);
    assign w_tmo_hit = (r_tmo == c_TMO_END);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, leave a grant on ack or timeout,
    // spend exactly one cycle in RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_dm) begin
                    w_next = S_GRANT_DM;
                end else if (w_pick_if) begin
                    w_next = S_GRANT_IF;
                end
            end
            S_GRANT_IF, S_GRANT_DM: begin
                if (i_mem_ack || w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Fairness counter: counts data grants taken while a fetch was waiting.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_run <= '0;
        end else if (r_state == S_IDLE) begin
            if (!i_if_req || w_pick_if) begin
                r_run <= '0;
            end else if (w_pick_dm && !w_run_sat) begin
                r_run <= r_run + c_RUN_ONE;
            end
        end
    end

    // Watchdog on the granted access: restarts with every new grant and
    // advances on each granted cycle that passes without an acknowledge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tmo <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pick_dm || w_pick_if) begin
                r_tmo <= '0;
            end
        end else if (w_granted && !i_mem_ack && !w_tmo_hit) begin
            r_tmo <= r_tmo + c_TMO_ONE;
        end
    end

    // Memory-side request: the winning port's attributes are frozen at grant
    // time so the memory sees a stable request for the whole access.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_dm) begin
                        r_mem_req   <= 1'b1;
                        r_mem_rw    <= i_dm_rw;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                    end else if (w_pick_if) begin
                        // Fetches are always reads; no write data applies.
                        r_mem_req   <= 1'b1;
                        r_mem_rw    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                S_GRANT_IF, S_GRANT_DM: begin
                    if (i_mem_ack || w_tmo_hit) begin
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response side: capture read data for the granted port and raise its
    // one-cycle ready. A timed-out access returns zero data plus o_error.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_if_data  <= '0;
            r_dm_rdata <= '0;
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_error    <= 1'b0;
            if (w_granted && (i_mem_ack || w_tmo_hit)) begin
                r_error <= !i_mem_ack;
                if (r_state == S_GRANT_IF) begin
                    r_if_ready <= 1'b1;
                    r_if_data  <= i_mem_ack ? i_mem_rdata : 32'h0;
                end else begin
                    r_dm_ready <= 1'b1;
                    r_dm_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
                end
            end
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_rw    = r_mem_rw;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_data   = r_if_data;
    assign o_if_ready  = r_if_ready;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_ready  = r_dm_ready;
    assign o_error     = r_error;

    // The pipeline stalls while any port has an outstanding, unfinished request.
    assign o_stall = (i_if_req & ~r_if_ready) | (i_dm_req & ~r_dm_ready);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter. A timeline model
//               predicts, per access, the grant window and ready cycle from
//               the arbitration rules and the configured memory latency; the
//               DUT outputs are compared against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int MAX_DATA_RUN = 4;
    localparam int TIMEOUT      = 255;

    logic        r_clk = 1'b0;
    logic        r_rst_n;
    logic        r_if_req;
    logic [15:0] r_if_addr;
    logic        r_dm_req;
    logic        r_dm_rw;
    logic [15:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [31:0] r_mem_rdata;
    logic        r_mem_ack;

    logic [31:0] w_if_data;
    logic        w_if_ready;
    logic [31:0] w_dm_rdata;
    logic        w_dm_ready;
    logic        w_mem_req;
    logic        w_mem_rw;
    logic [15:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_stall;
    logic        w_error;

    memory_arbiter #(
        .MAX_DATA_RUN (MAX_DATA_RUN),
        .TIMEOUT      (TIMEOUT)
    ) u_dut (
        .i_clk       (r_clk),
        .i_reset_n   (r_rst_n),
        .i_if_req    (r_if_req),
        .i_if_addr   (r_if_addr),
        .o_if_data   (w_if_data),
        .o_if_ready  (w_if_ready),
        .i_dm_req    (r_dm_req),
        .i_dm_rw     (r_dm_rw),
        .i_dm_addr   (r_dm_addr),
        .i_dm_wdata  (r_dm_wdata),
        .o_dm_rdata  (w_dm_rdata),
        .o_dm_ready  (w_dm_ready),
        .o_mem_req   (w_mem_req),
        .o_mem_rw    (w_mem_rw),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata),
        .i_mem_rdata (r_mem_rdata),
        .i_mem_ack   (r_mem_ack),
        .o_stall     (w_stall),
        .o_error     (w_error)
    );

    always #5 r_clk = ~r_clk;

    int cyc = 0;
    always @(posedge r_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // Memory contents seen by the bench.
    function automatic logic [31:0] mem_data(input logic [15:0] a);
        if (a == 16'h0010) return 32'h01020304;
        return {a ^ 16'hA5A5, a};
    endfunction

    // ---------------------------------------------------------------- memory
    int mem_lat   = 0;   // extra granted cycles before the ack
    bit mem_noack = 1'b0;
    bit spur      = 1'b0; // drive stray acks while no access is granted
    int gcnt      = 0;

    initial begin
        r_mem_ack   = 1'b0;
        r_mem_rdata = '0;
        forever begin
            @(posedge r_clk);
            #1;
            if (!r_rst_n) begin
                r_mem_ack = 1'b0;
                gcnt      = 0;
            end else if (w_mem_req) begin
                if (!mem_noack && gcnt == mem_lat) begin
                    r_mem_ack   = 1'b1;
                    r_mem_rdata = mem_data(w_mem_addr);
                end else begin
                    r_mem_ack   = 1'b0;
                    r_mem_rdata = 32'hBAD0BAD0;
                end
                gcnt++;
            end else begin
                gcnt        = 0;
                r_mem_ack   = spur;
                r_mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    // ------------------------------------------------------------ model
    // Each access is a window on the cycle timeline: arbitration in cycle c,
    // memory request over [c+1, c+1+L], ready at c+2+L, next arbitration at
    // c+3+L, where L is the memory latency or TIMEOUT-1 for a dead memory.
    int          g_start = 1, g_end = 0, r_cyc = -1, free_at = 0, run = 0, m_port = 0, lat_m = 0;
    logic [15:0] m_addr  = '0;
    logic        m_rw    = 1'b0;
    logic [31:0] m_wdata = '0;
    bit          m_noack = 1'b0;
    logic [31:0] exp_if_data = '0, exp_dm_data = '0;
    bit          in_g, is_r, e_if_rdy, e_dm_rdy;
    string       glog = "";

    initial begin
        forever begin
            @(negedge r_clk);
            if (!r_rst_n) begin
                g_start     = 1;
                g_end       = 0;
                r_cyc       = -1;
                free_at     = cyc;
                run         = 0;
                exp_if_data = '0;
                exp_dm_data = '0;
            end else begin
                in_g     = (cyc >= g_start) && (cyc <= g_end);
                is_r     = (cyc == r_cyc);
                e_if_rdy = is_r && (m_port == 0);
                e_dm_rdy = is_r && (m_port == 1);
                check("mem_req", 32'(w_mem_req), 32'(in_g));
                if (in_g) begin
                    check("mem_addr", 32'(w_mem_addr), 32'(m_addr));
                    check("mem_rw", 32'(w_mem_rw), 32'(m_rw));
                    if (m_port == 1) check("mem_wdata", w_mem_wdata, m_wdata);
                end
                check("if_ready", 32'(w_if_ready), 32'(e_if_rdy));
                check("dm_ready", 32'(w_dm_ready), 32'(e_dm_rdy));
                check("error", 32'(w_error), 32'(is_r && m_noack));
                if (e_if_rdy) exp_if_data = m_noack ? 32'h0 : mem_data(m_addr);
                if (e_dm_rdy) exp_dm_data = m_noack ? 32'h0 : mem_data(m_addr);
                check("if_data", w_if_data, exp_if_data);
                check("dm_rdata", w_dm_rdata, exp_dm_data);
                check("stall", 32'(w_stall),
                      32'((r_if_req && !e_if_rdy) || (r_dm_req && !e_dm_rdy)));

                if (cyc >= free_at) begin
                    if (!r_if_req) run = 0;
                    if (r_dm_req && !(r_if_req && run >= MAX_DATA_RUN)) begin
                        m_port  = 1;
                        m_addr  = r_dm_addr;
                        m_rw    = r_dm_rw;
                        m_wdata = r_dm_wdata;
                        glog    = {glog, "D"};
                        run     = r_if_req ? ((run < MAX_DATA_RUN) ? run + 1 : run) : 0;
                    end else if (r_if_req) begin
                        m_port  = 0;
                        m_addr  = r_if_addr;
                        m_rw    = 1'b0;
                        m_wdata = '0;
                        glog    = {glog, "F"};
                        run     = 0;
                    end
                    if (r_dm_req || r_if_req) begin
                        m_noack = mem_noack;
                        lat_m   = mem_noack ? TIMEOUT - 1 : mem_lat;
                        g_start = cyc + 1;
                        g_end   = cyc + 1 + lat_m;
                        r_cyc   = g_end + 1;
                        free_at = r_cyc + 1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    // Both drivers are entered just after a rising edge, hold the request
    // until the ready pulse and release it just after the following edge.
    task automatic fetch(input logic [15:0] addr, output int lat, output logic [31:0] data,
                         output int stall_hi, output logic stall_at_rdy);
        int t0;
        bit got;
        r_if_req     = 1'b1;
        r_if_addr    = addr;
        t0           = cyc;
        got          = 1'b0;
        lat          = -1;
        data         = '0;
        stall_hi     = 0;
        stall_at_rdy = 1'b1;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge r_clk);
            if (w_if_ready) begin
                got          = 1'b1;
                lat          = cyc - t0;
                data         = w_if_data;
                stall_at_rdy = w_stall;
            end else if (w_stall) begin
                stall_hi++;
            end
        end
        check("fetch_done", 32'(got), 32'd1);
        @(posedge r_clk);
        #1;
        r_if_req = 1'b0;
    endtask

    task automatic dm_access(input logic rw, input logic [15:0] addr, input logic [31:0] wd,
                             output int lat, output logic [31:0] data, output logic err);
        int t0;
        bit got;
        r_dm_req   = 1'b1;
        r_dm_rw    = rw;
        r_dm_addr  = addr;
        r_dm_wdata = wd;
        t0         = cyc;
        got        = 1'b0;
        lat        = -1;
        data       = '0;
        err        = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge r_clk);
            if (w_dm_ready) begin
                got  = 1'b1;
                lat  = cyc - t0;
                data = w_dm_rdata;
                err  = w_error;
            end
        end
        check("dm_done", 32'(got), 32'd1);
        @(posedge r_clk);
        #1;
        r_dm_req = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    int          lat_f, lat_d, sh_f, sh_d;
    logic [31:0] dat_f, dat_d;
    logic        sr_f, err_d;

    initial begin
        r_rst_n    = 1'b0;
        r_if_req   = 1'b0;
        r_if_addr  = '0;
        r_dm_req   = 1'b0;
        r_dm_rw    = 1'b0;
        r_dm_addr  = '0;
        r_dm_wdata = '0;
        repeat (2) @(posedge r_clk);
        #1;
        check("rst_mem_req",   32'(w_mem_req),   32'd0);
        check("rst_mem_rw",    32'(w_mem_rw),    32'd0);
        check("rst_mem_addr",  32'(w_mem_addr),  32'd0);
        check("rst_mem_wdata", w_mem_wdata,      32'd0);
        check("rst_if_data",   w_if_data,        32'd0);
        check("rst_dm_rdata",  w_dm_rdata,       32'd0);
        check("rst_if_ready",  32'(w_if_ready),  32'd0);
        check("rst_dm_ready",  32'(w_dm_ready),  32'd0);
        check("rst_error",     32'(w_error),     32'd0);
        r_rst_n = 1'b1;
        @(posedge r_clk);
        #1;

        // Fetch alone, minimum latency.
        mem_lat = 0;
        fetch(16'h0010, lat_f, dat_f, sh_f, sr_f);
        check("fetch_lat", 32'(lat_f), 32'd2);
        check("fetch_data", dat_f, 32'h01020304);

        // Simultaneous requests: the data write wins, then the fetch.
        glog = "";
        fork
            dm_access(1'b1, 16'h0040, 32'hDEADBEEF, lat_d, dat_d, err_d);
            fetch(16'h0044, lat_f, dat_f, sh_f, sr_f);
            begin
                repeat (2) @(negedge r_clk);
                check("sim_gnt_rw",    32'(w_mem_rw),   32'd1);
                check("sim_gnt_wdata", w_mem_wdata,     32'hDEADBEEF);
                check("sim_gnt_addr",  32'(w_mem_addr), 32'h0040);
            end
        join
        check_str("sim_order", glog, "DF");
        check("wr_rdata", dat_d, mem_data(16'h0040));

        // Fetch held against five back-to-back data reads, with stray acks
        // between accesses.
        glog = "";
        spur = 1'b1;
        fork
            fetch(16'h0080, lat_f, dat_f, sh_f, sr_f);
            begin
                for (int i = 0; i < 5; i++) begin
                    dm_access(1'b0, 16'h0100 + 16'(i * 4), 32'h0, lat_d, dat_d, err_d);
                end
            end
        join
        spur = 1'b0;
        check_str("run_order", glog, "DDDDFD");
        check("run_last_data", dat_d, mem_data(16'h0110));

        // Data read against a dead memory: timeout abort.
        mem_noack = 1'b1;
        dm_access(1'b0, 16'h0200, 32'h0, lat_d, dat_d, err_d);
        check("tmo_lat", 32'(lat_d), 32'(TIMEOUT + 1));
        check("tmo_error", 32'(err_d), 32'd1);
        check("tmo_rdata", dat_d, 32'd0);
        check("tmo_req_after", 32'(w_mem_req), 32'd0);
        mem_noack = 1'b0;

        // Stall over a fetch with three granted cycles.
        mem_lat = 2;
        fetch(16'h0500, lat_f, dat_f, sh_f, sr_f);
        check("stall_lat", 32'(lat_f), 32'd4);
        check("stall_cycles", 32'(sh_f), 32'd4);
        check("stall_at_ready", 32'(sr_f), 32'd0);
        mem_lat = 0;

        // Reset in the middle of a data grant, with a fetch also pending.
        mem_noack  = 1'b1;
        r_dm_req   = 1'b1;
        r_dm_rw    = 1'b0;
        r_dm_addr  = 16'h0300;
        r_dm_wdata = 32'h12345678;
        r_if_req   = 1'b1;
        r_if_addr  = 16'h0400;
        repeat (4) @(negedge r_clk);
        check("pre_rst_req", 32'(w_mem_req), 32'd1);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("arst_mem_req",   32'(w_mem_req),  32'd0);
        check("arst_mem_rw",    32'(w_mem_rw),   32'd0);
        check("arst_mem_addr",  32'(w_mem_addr), 32'd0);
        check("arst_mem_wdata", w_mem_wdata,     32'd0);
        check("arst_if_data",   w_if_data,       32'd0);
        check("arst_dm_rdata",  w_dm_rdata,      32'd0);
        check("arst_if_ready",  32'(w_if_ready), 32'd0);
        check("arst_dm_ready",  32'(w_dm_ready), 32'd0);
        check("arst_error",     32'(w_error),    32'd0);
        @(posedge r_clk);
        #1;
        r_dm_req  = 1'b0;
        mem_noack = 1'b0;
        @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;
        fetch(16'h0400, lat_f, dat_f, sh_f, sr_f);
        check("post_rst_lat", 32'(lat_f), 32'd2);
        check("post_rst_data", dat_f, mem_data(16'h0400));

        repeat (3) @(posedge r_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter MAX_DATA_RUN, default 4: maximum consecutive data-port grants while a fetch request is pending.
REQ-002 Parameter TIMEOUT, default 255: number of granted cycles without i_mem_ack before the access is aborted.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_if_req  input  1  instruction fetch request, held until o_if_ready.
REQ-006 i_if_addr  input  16  fetch address (the pc).
REQ-007 o_if_data  output  32  fetched instruction, valid while o_if_ready=1.
REQ-008 o_if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 i_dm_req  input  1  data access request, held until o_dm_ready.
REQ-010 i_dm_rw  input  1  0=read, 1=write.
REQ-011 i_dm_addr  input  16  data address.
REQ-012 i_dm_wdata  input  32  write data.
REQ-013 o_dm_rdata  output  32  read data, valid while o_dm_ready=1.
REQ-014 o_dm_ready  output  1  one-cycle data completion pulse.
REQ-015 o_mem_req  output  1  shared memory request, high for the whole granted access.
REQ-016 o_mem_rw  output  1  shared memory direction, 0=read, 1=write.
REQ-017 o_mem_addr  output  16  shared memory address.
REQ-018 o_mem_wdata  output  32  shared memory write data.
REQ-019 i_mem_rdata  input  32  memory read data, sampled in the i_mem_ack cycle.
REQ-020 i_mem_ack  input  1  memory completion, single-cycle pulse.
REQ-021 o_stall  output  1  pipeline stall indication.
REQ-022 o_error  output  1  one-cycle pulse marking a timed-out access.

Function
REQ-023 FSM states: IDLE, GRANT_IF, GRANT_DM, RESP.
REQ-024 In IDLE with i_dm_req=1, next state is GRANT_DM, except when i_if_req=1 and run count >= MAX_DATA_RUN, in which case next state is GRANT_IF.
REQ-025 In IDLE with only i_if_req=1, next state is GRANT_IF; with no request pending, the FSM stays in IDLE.
REQ-026 On entry to GRANT_*, the granted port's address, rw and wdata are registered and drive o_mem_* unchanged until the access ends; fetch accesses always drive rw=0.
REQ-027 o_mem_req is 1 exactly in the GRANT_IF and GRANT_DM states.
REQ-028 A GRANT_* state with i_mem_ack=1 moves to RESP and captures i_mem_rdata into the granted port's data register.
REQ-029 RESP lasts one cycle, asserts only the granted port's ready, then returns to IDLE; requests are not arbitrated during RESP.
REQ-030 Minimum latency: request seen in IDLE at cycle t, o_mem_req high at t+1, ack at t+1, ready at t+2, IDLE at t+3.
REQ-031 Run counter (3 bits minimum, saturating at MAX_DATA_RUN): +1 on each GRANT_DM entry while i_if_req=1; cleared on GRANT_IF entry or when i_if_req=0 in IDLE.
REQ-032 Timeout counter: cleared on GRANT_* entry, +1 on each granted cycle without ack.
REQ-033 When the timeout counter reaches TIMEOUT-1 without ack, the access is aborted: o_mem_req drops, the FSM enters RESP, ready and o_error pulse together, and the data register is 0.
REQ-034 i_mem_ack while not in a GRANT_* state is ignored.
REQ-035 o_if_data and o_dm_rdata hold their last captured value outside the ready cycle.
REQ-036 o_stall = (i_if_req & ~o_if_ready) | (i_dm_req & ~o_dm_ready), combinational.
REQ-037 A write access returns o_dm_rdata = i_mem_rdata at ack; the CPU ignores this value.

Reset
REQ-038 Asynchronous reset forces IDLE, clears both counters, and sets every registered output to 0: o_mem_req, o_mem_rw, o_mem_addr, o_mem_wdata, o_if_data, o_dm_rdata, o_if_ready, o_dm_ready, o_error.
REQ-039 Reset during GRANT_* abandons the access with no ready pulse; o_mem_req falls immediately, without waiting for a clock edge.
REQ-040 After reset release, the first arbitration happens on the first rising edge with a request present.

Verification
REQ-041 Fetch only: if_addr=0x0010, ack after 1 cycle with rdata=0x01020304 -> o_if_ready pulse with o_if_data=0x01020304 at t+2; o_mem_rw=0 throughout.
REQ-042 Simultaneous requests, dm write addr=0x0040 wdata=0xDEADBEEF -> data is granted first: o_mem_rw=1, o_mem_wdata=0xDEADBEEF; the fetch is granted on the next IDLE.
REQ-043 Fetch held, 5 back-to-back data requests, MAX_DATA_RUN=4 -> grants occur in the order D,D,D,D,F,D.
REQ-044 Data read with no ack for 255 cycles -> o_dm_ready and o_error pulse in the same cycle, o_dm_rdata=0, o_mem_req low afterwards.
REQ-045 Reset asserted mid-GRANT_DM -> all outputs 0 asynchronously, no ready pulse; after release, a pending fetch is served normally.
REQ-046 o_stall check: a fetch with 3-cycle memory latency -> o_stall high from the request until the ready cycle, low in the ready cycle.
